// File: rtl/ingress_pkt_buffer.sv
// ingress_pkt_buffer
//   Store-and-forward packet buffer sitting in front of one switch ingress
//   port. Words from the source are written into a circular RAM. A packet
//   becomes visible to the read side only once its eop has been written.
//   The read side then streams the packet to the switch as one unbroken
//   burst. A burst may start only while alm_ost_full is low.
//   Packets that are abandoned (a new sop arrives before eop) or that overflow
//   the buffer are rewound out of the RAM and counted in drop_cnt.
//
// Ports
//   external_clk, rst          : clock, async active-high reset
//   in_sop/in_eop/in_vld/in_data: source side framing and data
//   in_ready                   : buffer not full (combinational)
//   alm_ost_full               : switch backpressure, sampled between packets
//   wr_sop/wr_eop/wr_vld/wr_data: registered burst towards the switch
//   pkt_cnt                    : complete packets currently stored
//   drop_cnt                   : dropped packets, saturating
module ingress_pkt_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       external_clk,
  input  logic                       rst,
  input  logic                       in_sop,
  input  logic                       in_eop,
  input  logic                       in_vld,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       in_ready,
  input  logic                       alm_ost_full,
  output logic                       wr_sop,
  output logic                       wr_eop,
  output logic                       wr_vld,
  output logic [DATA_WIDTH-1:0]      wr_data,
  output logic [$clog2(DEPTH):0]     pkt_cnt,
  output logic [CNT_WIDTH-1:0]       drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {IDLE, SEND} state_t;

  // RAM word = {eop flag, data}
  logic [DATA_WIDTH:0] mem [DEPTH];

  logic [PW-1:0] wptr, rptr, pkt_start;
  logic          wr_busy;
  logic          fifo_full;
  state_t        state;

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  logic          ovf, accept, restart, commit, drop;
  logic [PW-1:0] wr_addr;

  // Occupancy uses the registered rptr, so space freed this cycle is only
  // seen next cycle.
  assign fifo_full = (wptr - rptr) == PW'(DEPTH);
  assign in_ready  = !fifo_full;

  // Overflow takes priority: a full buffer with a packet in progress can
  // never complete that packet, so it is dropped whatever the word is.
  assign ovf     = in_vld && fifo_full && wr_busy;
  assign accept  = in_vld && !fifo_full && (in_sop || wr_busy);
  // A sop during an open packet overwrites it from its own start.
  assign restart = accept && in_sop && wr_busy;
  assign wr_addr = restart ? pkt_start : wptr;
  assign commit  = accept && in_eop;
  assign drop    = ovf || restart;

  always_ff @(posedge external_clk) begin
    if (accept) mem[wr_addr[AW-1:0]] <= {in_eop, in_data};
  end

  always_ff @(posedge external_clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      pkt_start <= '0;
      wr_busy   <= 1'b0;
    end else if (ovf) begin
      wptr    <= pkt_start;
      wr_busy <= 1'b0;
    end else if (accept) begin
      wptr    <= wr_addr + PW'(1);
      if (in_sop) pkt_start <= wr_addr;
      wr_busy <= !in_eop;
    end
  end

  always_ff @(posedge external_clk or posedge rst) begin
    if (rst)                            drop_cnt <= '0;
    else if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
  end

  // ---------------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH:0] rd_word;
  logic                rd_eop, rd_start, rd_done;

  assign rd_word  = mem[rptr[AW-1:0]];
  assign rd_eop   = rd_word[DATA_WIDTH];
  // !wr_vld forces one empty cycle after every burst before the next sop.
  assign rd_start = (state == IDLE) && (pkt_cnt != '0) && !alm_ost_full && !wr_vld;
  assign rd_done  = rd_eop && (rd_start || (state == SEND));

  always_ff @(posedge external_clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rptr    <= '0;
      wr_vld  <= 1'b0;
      wr_sop  <= 1'b0;
      wr_eop  <= 1'b0;
      wr_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_start) begin
            wr_vld  <= 1'b1;
            wr_sop  <= 1'b1;
            wr_eop  <= rd_eop;
            wr_data <= rd_word[DATA_WIDTH-1:0];
            rptr    <= rptr + PW'(1);
            state   <= rd_eop ? IDLE : SEND;
          end else begin
            wr_vld <= 1'b0;
            wr_sop <= 1'b0;
            wr_eop <= 1'b0;
          end
        end
        SEND: begin
          wr_vld  <= 1'b1;
          wr_sop  <= 1'b0;
          wr_eop  <= rd_eop;
          wr_data <= rd_word[DATA_WIDTH-1:0];
          rptr    <= rptr + PW'(1);
          if (rd_eop) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge external_clk or posedge rst) begin
    if (rst) pkt_cnt <= '0;
    else begin
      case ({commit, rd_done})
        2'b10:   pkt_cnt <= pkt_cnt + PW'(1);
        2'b01:   pkt_cnt <= pkt_cnt - PW'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_ingress_pkt_buffer.sv
// Testbench for ingress_pkt_buffer (DEPTH=8). A queue-based reference model
// predicts which words reach the switch; predicted words go into a scoreboard
// queue that an independent monitor drains whenever wr_vld is seen.
module tb_ingress_pkt_buffer;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int CW    = 16;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_sop, in_eop, in_vld, alm;
  logic [DW-1:0] in_data;
  logic          in_ready, wr_sop, wr_eop, wr_vld;
  logic [DW-1:0] wr_data;
  logic [PW-1:0] pkt_cnt;
  logic [CW-1:0] drop_cnt;

  always #5 clk = ~clk;

  ingress_pkt_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .external_clk(clk), .rst(rst),
    .in_sop(in_sop), .in_eop(in_eop), .in_vld(in_vld), .in_data(in_data),
    .in_ready(in_ready), .alm_ost_full(alm),
    .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_vld(wr_vld), .wr_data(wr_data),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
  } word_t;

  int compared   = 0;
  int mismatched = 0;

  // reference model state
  word_t stored[$];   // committed, not yet forwarded words
  word_t cur[$];      // packet being assembled
  word_t exp_q[$];    // scoreboard
  bit    busy;
  int    drops;
  int    burst_left;
  bit    prev_out;
  bit    exp_vld;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int npk();
    int n = 0;
    foreach (stored[i]) if (stored[i].eop) n++;
    return n;
  endfunction

  function automatic bit model_full();
    return (stored.size() + cur.size()) == DEPTH;
  endfunction

  task automatic model_reset();
    stored.delete(); cur.delete(); exp_q.delete();
    busy = 0; drops = 0; burst_left = 0; prev_out = 0; exp_vld = 0;
  endtask

  task automatic commit_cur();
    foreach (cur[i]) stored.push_back(cur[i]);
    cur.delete();
    busy = 0;
  endtask

  // One clock edge of behaviour, evaluated on pre-edge state.
  task automatic model_edge(input bit s, input bit e, input bit v,
                            input logic [DW-1:0] d, input bit a);
    bit    full;
    word_t w;
    full    = model_full();
    exp_vld = 0;
    // forward: whole packets, one word per cycle, a quiet cycle between them,
    // start gated by backpressure only
    if (burst_left == 0 && !prev_out && npk() > 0 && !a) begin
      for (int i = 0; i < stored.size(); i++)
        if (stored[i].eop) begin burst_left = i + 1; break; end
    end
    if (burst_left > 0) begin
      w = stored.pop_front();
      exp_q.push_back(w);
      burst_left--;
      exp_vld = 1;
    end
    prev_out = exp_vld;
    // store
    if (v) begin
      if (full && busy) begin
        cur.delete(); busy = 0; drops++;
      end else if (!full && s) begin
        if (busy) begin cur.delete(); drops++; end
        w.d = d; w.sop = 1'b1; w.eop = e;
        cur.push_back(w); busy = 1;
        if (e) commit_cur();
      end else if (!full && busy) begin
        w.d = d; w.sop = 1'b0; w.eop = e;
        cur.push_back(w);
        if (e) commit_cur();
      end
    end
  endtask

  // Called right after a falling edge.
  task automatic step(input bit s, input bit e, input bit v,
                      input logic [DW-1:0] d, input bit a);
    in_sop = s; in_eop = e; in_vld = v; in_data = d; alm = a;
    #1;
    chk("in_ready", in_ready, !model_full());
    model_edge(s, e, v, d, a);
    @(posedge clk);
    @(negedge clk);
    chk("pkt_cnt", pkt_cnt, npk());
    chk("drop_cnt", drop_cnt, drops);
    chk("wr_vld", wr_vld, exp_vld);
  endtask

  task automatic idle(input int n, input bit a);
    for (int i = 0; i < n; i++) step(0, 0, 0, DW'($urandom), a);
  endtask

  task automatic send_pkt(input int len, input bit a, input bit term);
    for (int i = 0; i < len; i++)
      step(i == 0, term && (i == len - 1), 1, DW'($urandom), a);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    word_t w;
    if (!rst && wr_vld) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL out_word: unexpected word %0h sop=%0b eop=%0b at %0t",
                 wr_data, wr_sop, wr_eop, $time);
      end else begin
        w = exp_q.pop_front();
        if (wr_data !== w.d || wr_sop !== w.sop || wr_eop !== w.eop) begin
          mismatched++;
          $display("FAIL out_word: got %0h/%0b/%0b expected %0h/%0b/%0b at %0t",
                   wr_data, wr_sop, wr_eop, w.d, w.sop, w.eop, $time);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_sop = 0; in_eop = 0; in_vld = 0; in_data = '0; alm = 0;
    model_reset();
    #2;
    chk("rst_wr_vld", wr_vld, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // single 4-word packet
    send_pkt(4, 0, 1);
    idle(8, 0);

    // two packets held by backpressure, alm re-raised during the first burst
    send_pkt(3, 1, 1);
    send_pkt(1, 1, 1);
    idle(3, 1);
    chk("held_pkt_cnt", pkt_cnt, 2);
    idle(1, 0);
    idle(6, 1);
    idle(4, 0);

    // oversize packet while blocked, then a normal one
    send_pkt(10, 1, 1);
    chk("ovf_drop", drop_cnt, 1);
    send_pkt(2, 0, 1);
    idle(6, 0);

    // abandoned packet
    send_pkt(2, 0, 0);
    send_pkt(3, 0, 1);
    idle(6, 0);

    // stray words without sop
    for (int i = 0; i < 3; i++) step(0, i == 2, 1, DW'($urandom), 0);
    idle(2, 0);

    // reset in the middle of a burst
    send_pkt(2, 0, 0);
    send_pkt(5, 0, 1);
    idle(3, 0);
    rst = 1'b1;
    #1;
    chk("rst_mid_vld", wr_vld, 0);
    chk("rst_mid_sop", wr_sop, 0);
    chk("rst_mid_eop", wr_eop, 0);
    chk("rst_mid_data", wr_data, 0);
    chk("rst_mid_pkt_cnt", pkt_cnt, 0);
    chk("rst_mid_drop_cnt", drop_cnt, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic
    for (int p = 0; p < 400; p++) begin
      int kind = $urandom_range(0, 9);
      bit a    = ($urandom_range(0, 9) < 2);
      if (kind < 7)      send_pkt($urandom_range(1, 10), a, 1);
      else if (kind < 8) send_pkt($urandom_range(1, 4), a, 0);
      else               step(0, $urandom_range(0, 1), 1, DW'($urandom), a);
      idle($urandom_range(0, 2), ($urandom_range(0, 9) < 2));
    end
    idle(40, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
